// File: rtl/sw_cond_pkg.sv
// Shared constants for the slide-switch conditioning path feeding the adder.
package sw_cond_pkg;
    localparam int SW_WIDTH           = 3;
    localparam int SW_DB_CYCLES_SYNTH = 1_000_000;
    localparam int SW_DB_CYCLES_SIM   = 4;
    localparam int SW_SYNC_STAGES     = 2;
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, bounce counter and accepted-level flop
// with registered rise/fall pulses aligned to the level update.
module sw_debounce_bit #(
    parameter int DB_CYCLES   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end

    // Any cycle of agreement restarts the window, so a bounce costs a full
    // DB_CYCLES again; the counter is cleared on acceptance and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync != q) begin
                if (cnt == CNT_LAST) begin
                    q    <= sync;
                    cnt  <= '0;
                    rise <= sync;
                    fall <= ~sync;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/sw_debounce.sv
// Debounces the slide-switch vector ahead of the adder; sw_out replaces the raw
// switch bus as operand/carry-in source.
module sw_debounce
    import sw_cond_pkg::*;
#(
    parameter int WIDTH       = SW_WIDTH,
    parameter int DB_CYCLES   = SW_DB_CYCLES_SYNTH,
    parameter int SYNC_STAGES = SW_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (sw_in[i]),
            .q     (sw_out[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

    // Decoded only from the per-bit pulse flops, so it lines up with sw_out
    // and has no path from sw_in.
    assign sw_changed = |(sw_rise | sw_fall);
endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a window-based reference model queues the
// expected outputs for each edge, a monitor pops and compares after the edge.
module tb_sw_debounce;
    import sw_cond_pkg::*;

    localparam int W    = SW_WIDTH;
    localparam int DB   = SW_DB_CYCLES_SIM;
    localparam int SYNC = SW_SYNC_STAGES;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out, sw_rise, sw_fall;
    logic         sw_changed;

    int checks = 0;
    int errors = 0;

    exp_t         expq[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] seen[$];
    logic [W-1:0] stable = '0;

    sw_debounce #(.WIDTH(W), .DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .sw_out     (sw_out),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Reference: an edge accepts a bit when the synchronised value seen on each
    // of the last DB edges differs from the accepted level.
    task automatic step(input logic [W-1:0] v, input logic r);
        exp_t         e;
        logic [W-1:0] s;
        logic         acc;
        int           n;
        @(negedge clk);
        sw_in = v;
        rst_n = r;
        e = '0;
        if (!r) begin
            hist.delete();
            seen.delete();
            stable = '0;
        end else begin
            hist.push_back(v);
            s = (hist.size() > SYNC) ? hist[hist.size()-1-SYNC] : '0;
            seen.push_back(s);
            n = seen.size();
            for (int b = 0; b < W; b++) begin
                acc = (n >= DB);
                for (int j = 0; j < DB && j < n; j++)
                    if (seen[n-1-j][b] == stable[b]) acc = 1'b0;
                if (acc) begin
                    stable[b] = ~stable[b];
                    e.rise[b] = stable[b];
                    e.fall[b] = ~stable[b];
                end
            end
            e.out = stable;
            e.chg = |(e.rise | e.fall);
        end
        expq.push_back(e);
        if (!r) begin
            #1;
            chk("async_rst_out", sw_out, '0);
            chk("async_rst_pulse", sw_rise | sw_fall | W'(sw_changed), '0);
        end
    endtask

    task automatic hold(input logic [W-1:0] v, input int cycles);
        for (int k = 0; k < cycles; k++) step(v, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sw_out", sw_out, e.out);
                chk("sw_rise", sw_rise, e.rise);
                chk("sw_fall", sw_fall, e.fall);
                chk("sw_changed", W'(sw_changed), W'(e.chg));
                chk("rise_fall_excl", sw_rise & sw_fall, '0);
            end
        end
    end

    initial begin : stim
        logic [W-1:0] v;
        step('0, 1'b0);
        step('0, 1'b0);
        hold(3'b000, 20);
        hold(3'b001, 10);
        // bounce on bit 1
        hold(3'b011, 3);
        hold(3'b001, 1);
        hold(3'b011, 10);
        // simultaneous change on two bits
        hold(3'b110, 10);
        // reset mid-count with switches held high
        hold(3'b111, 3);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        hold(3'b111, 10);
        hold(3'b000, 10);
        // short glitch on bit 2
        hold(3'b100, 3);
        hold(3'b000, 10);
        // random slow-changing switches with occasional reset
        v = '0;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            step(v, ($urandom_range(0, 149) != 0));
        end
        hold(v, 12);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
